// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds,
// overflow/underflow pulses and optional first-word-fall-through read mode.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2,
    parameter bit FWFT      = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en_i,
    input  logic [DATA_W-1:0]          data_i,
    input  logic                       rd_en_i,
    output logic [DATA_W-1:0]          data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);
    localparam logic [AW:0] FULL_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_THRESH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       count;
    logic              wr_acc;
    logic              rd_acc;
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     rd_idx;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];

    assign count_o        = count;
    assign empty_o        = (count == '0);
    assign full_o         = (count == FULL_C);
    assign almost_full_o  = (count >= AF_C);
    assign almost_empty_o = (count <= AE_C);

    // A write into a full FIFO is still accepted when a read frees a slot this cycle.
    always_comb begin
        rd_acc = rd_en_i & ~empty_o;
        wr_acc = wr_en_i & (~full_o | rd_acc);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            overflow_o  <= wr_en_i & ~wr_acc;
            underflow_o <= rd_en_i & ~rd_acc;
            if (wr_acc) wr_ptr <= wr_ptr + ONE;
            if (rd_acc) rd_ptr <= rd_ptr + ONE;
            unique case ({wr_acc, rd_acc})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_idx] <= data_i;
    end

    generate
        if (FWFT) begin : g_fwft
            assign data_o = empty_o ? '0 : mem[rd_idx];
        end else begin : g_std
            logic [DATA_W-1:0] data_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)        data_q <= '0;
                else if (rd_acc) data_q <= mem[rd_idx];
            end
            assign data_o = data_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a standard-read instance and an FWFT instance.
module tb_sync_fifo_param;

    logic       clk;
    logic       rst;

    logic       a_wr, a_rd;
    logic [7:0] a_din, a_dout;
    logic       a_full, a_empty, a_af, a_ae, a_ov, a_un;
    logic [3:0] a_cnt;

    logic       b_wr, b_rd;
    logic [7:0] b_din, b_dout;
    logic       b_full, b_empty, b_af, b_ae, b_ov, b_un;
    logic [3:0] b_cnt;

    int tests_run;
    int tests_failed;

    sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b0)) dut_std (
        .clk(clk), .rst(rst),
        .wr_en_i(a_wr), .data_i(a_din), .rd_en_i(a_rd), .data_o(a_dout),
        .full_o(a_full), .empty_o(a_empty), .almost_full_o(a_af), .almost_empty_o(a_ae),
        .count_o(a_cnt), .overflow_o(a_ov), .underflow_o(a_un)
    );

    sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b1)) dut_fwft (
        .clk(clk), .rst(rst),
        .wr_en_i(b_wr), .data_i(b_din), .rd_en_i(b_rd), .data_o(b_dout),
        .full_o(b_full), .empty_o(b_empty), .almost_full_o(b_af), .almost_empty_o(b_ae),
        .count_o(b_cnt), .overflow_o(b_ov), .underflow_o(b_un)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a_reset(input string tag);
        chk({tag, "_a_cnt"},   32'(a_cnt),   32'd0);
        chk({tag, "_a_empty"}, 32'(a_empty), 32'd1);
        chk({tag, "_a_full"},  32'(a_full),  32'd0);
        chk({tag, "_a_af"},    32'(a_af),    32'd0);
        chk({tag, "_a_ae"},    32'(a_ae),    32'd1);
        chk({tag, "_a_data"},  32'(a_dout),  32'd0);
        chk({tag, "_a_ov"},    32'(a_ov),    32'd0);
        chk({tag, "_a_un"},    32'(a_un),    32'd0);
        chk({tag, "_b_cnt"},   32'(b_cnt),   32'd0);
        chk({tag, "_b_empty"}, 32'(b_empty), 32'd1);
        chk({tag, "_b_data"},  32'(b_dout),  32'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst   = 1'b0;
        a_wr  = 1'b0; a_rd = 1'b0; a_din = 8'h00;
        b_wr  = 1'b0; b_rd = 1'b0; b_din = 8'h00;

        #1;
        chk_a_reset("por");
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Fill 0..7, flags follow registered count
        for (int i = 0; i < 8; i++) begin
            a_wr  = 1'b1;
            a_din = 8'(i);
            tick();
            chk("fill_cnt",   32'(a_cnt),  32'(i + 1));
            chk("fill_af",    32'(a_af),   32'((i + 1) >= 6));
            chk("fill_ae",    32'(a_ae),   32'((i + 1) <= 2));
            chk("fill_full",  32'(a_full), 32'((i + 1) == 8));
        end
        a_din = 8'h99;
        tick();
        chk("ovf_pulse", 32'(a_ov),  32'd1);
        chk("ovf_cnt",   32'(a_cnt), 32'd8);
        a_wr = 1'b0;
        tick();
        chk("ovf_clear", 32'(a_ov),  32'd0);

        // Drain with 1-cycle read latency
        a_rd = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("drain_data", 32'(a_dout), 32'(i));
            chk("drain_cnt",  32'(a_cnt),  32'(7 - i));
        end
        chk("drain_empty", 32'(a_empty), 32'd1);
        tick();
        chk("udf_pulse", 32'(a_un),   32'd1);
        chk("udf_hold",  32'(a_dout), 32'h07);
        a_rd = 1'b0;
        tick();
        chk("udf_clear", 32'(a_un),   32'd0);
        chk("idle_hold", 32'(a_dout), 32'h07);

        // Full plus simultaneous write/read, pointers wrap
        a_wr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_din = 8'(8'h10 + i);
            tick();
        end
        chk("full2", 32'(a_full), 32'd1);
        a_din = 8'hAA;
        a_rd  = 1'b1;
        tick();
        a_wr = 1'b0;
        chk("fullrw_ov",   32'(a_ov),   32'd0);
        chk("fullrw_cnt",  32'(a_cnt),  32'd8);
        chk("fullrw_data", 32'(a_dout), 32'h10);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("wrap_data", 32'(a_dout), 32'(8'h10 + i));
        end
        tick();
        chk("wrap_last", 32'(a_dout), 32'hAA);
        chk("wrap_cnt",  32'(a_cnt),  32'd0);

        // Empty plus simultaneous write/read
        a_wr  = 1'b1;
        a_din = 8'h3C;
        tick();
        a_wr = 1'b0;
        chk("emptyrw_un",   32'(a_un),   32'd1);
        chk("emptyrw_cnt",  32'(a_cnt),  32'd1);
        chk("emptyrw_hold", 32'(a_dout), 32'hAA);
        tick();
        a_rd = 1'b0;
        chk("emptyrw_data", 32'(a_dout), 32'h3C);
        chk("emptyrw_cnt0", 32'(a_cnt),  32'd0);
        chk("emptyrw_unc",  32'(a_un),   32'd0);

        // FWFT: head word visible without a read
        b_wr  = 1'b1;
        b_din = 8'h5A;
        tick();
        b_wr = 1'b0;
        chk("fwft_data",  32'(b_dout),  32'h5A);
        chk("fwft_empty", 32'(b_empty), 32'd0);
        chk("fwft_cnt",   32'(b_cnt),   32'd1);
        tick();
        chk("fwft_stay",  32'(b_dout),  32'h5A);
        b_rd = 1'b1;
        tick();
        b_rd = 1'b0;
        chk("fwft_pop_empty", 32'(b_empty), 32'd1);
        chk("fwft_pop_data",  32'(b_dout),  32'd0);
        b_wr  = 1'b1;
        b_din = 8'h11;
        tick();
        chk("fwft_d11", 32'(b_dout), 32'h11);
        b_din = 8'h22;
        b_rd  = 1'b1;
        tick();
        b_wr = 1'b0;
        b_rd = 1'b0;
        chk("fwft_rw_data", 32'(b_dout), 32'h22);
        chk("fwft_rw_cnt",  32'(b_cnt),  32'd1);

        // Asynchronous reset in the middle of a write burst
        a_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_din = 8'(8'h40 + i);
            tick();
        end
        chk("burst_cnt", 32'(a_cnt), 32'd3);
        rst = 1'b0;
        #1;
        chk_a_reset("async");
        a_wr = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("post_rst_cnt", 32'(a_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
